// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter.
//   ST_IDLE / ST_GRANT : FSM state encoding
//   clog2              : ceiling log2, returns 0 for inputs 0 and 1
package arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = unsigned'(i) + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
//   req       : per-requester level request
//   done      : release strobe from the current owner
//   gnt       : one-hot grant
//   gnt_code  : binary index of the granted requester
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse when a grant is revoked by the hold limit
// master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
);

  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_code;
  logic         gnt_valid;
  logic         timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_code,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_code,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker.
//   i_req  : request vector
//   i_ptr  : index with highest priority (0..N-1)
//   o_pick : first set request scanning i_ptr, i_ptr+1, .., wrapping at N
//   o_any  : at least one request is set
module rr_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_pick,
  output logic         o_any
);

  localparam logic [W:0] N_VAL = (W+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W-1:0]   w_idx;
  logic [W:0]     w_sum;

  // Doubling the vector turns the rotate into a plain shift, valid for any N.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  // Lowest index wins.
  always_comb begin
    w_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = W'(i);
    end
  end

  assign w_sum  = {1'b0, w_idx} + {1'b0, i_ptr};
  assign o_pick = (w_sum >= N_VAL) ? W'(w_sum - N_VAL) : w_sum[W-1:0];
  assign o_any  = |i_req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a grant hold limit.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : rr_arbiter_if slave (req/done in, gnt/gnt_code/gnt_valid/timeout out)
// A grant is held until the owner drops req, pulses done, or MAX_HOLD cycles elapse
// (MAX_HOLD = 0 disables the limit). One idle cycle always separates grants.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned W        = clog2(N),
  parameter int unsigned MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_if.slave  bus
);

  localparam int unsigned     CNT_W    = clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [W-1:0]    LAST_IDX = W'(N - 1);
  localparam logic [N-1:0]    ONE_HOT0 = N'(1);

  logic             r_state;
  logic [W-1:0]     r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_gnt;
  logic [W-1:0]     r_gnt_code;
  logic             r_gnt_valid;
  logic             r_timeout;

  logic             w_state_nxt;
  logic [W-1:0]     w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic [W-1:0]     w_code_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;

  logic [W-1:0]     w_pick;
  logic             w_any;
  logic             w_owner_req;
  logic             w_expire;
  logic             w_release;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_owner_req = bus.req[r_gnt_code];
  assign w_expire    = (MAX_HOLD != 0) && (r_cnt == CNT_LAST);
  assign w_release   = !w_owner_req || bus.done || w_expire;

  // State register plus all datapath/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_gnt_code  <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_code  <= w_code_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_release) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_code_nxt    = r_gnt_code;
    w_valid_nxt   = r_gnt_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = ONE_HOT0 << w_pick;
          w_code_nxt  = w_pick;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_gnt_nxt     = '0;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = (r_gnt_code == LAST_IDX) ? '0 : r_gnt_code + 1'b1;
          // Only a pure hold-limit release is flagged.
          w_timeout_nxt = w_expire && w_owner_req && !bus.done;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_code  = r_gnt_code;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

  localparam int unsigned N    = 8;
  localparam int unsigned W    = 3;
  localparam int unsigned MAXH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_arbiter_if #(.N(N), .W(W)) bus ();

  rr_arbiter #(
    .N        (N),
    .W        (W),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] code;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vecs[13];

  // Reference model: who owns the resource, for how many cycles, and where the
  // round-robin scan resumes. Updated from the inputs seen at each rising edge.
  bit m_busy = 1'b0;
  bit m_to   = 1'b0;
  int m_code = 0;
  int m_ptr  = 0;
  int m_held = 0;

  always @(posedge clk) begin
    int pick;
    pick = -1;
    if (rst) begin
      m_busy <= 1'b0;
      m_to   <= 1'b0;
      m_code <= 0;
      m_ptr  <= 0;
      m_held <= 0;
    end else if (!m_busy) begin
      m_to <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        if (pick < 0 && bus.req[(m_ptr + k) % int'(N)]) pick = (m_ptr + k) % int'(N);
      end
      if (pick >= 0) begin
        m_busy <= 1'b1;
        m_code <= pick;
        m_held <= 1;
      end
    end else if (!bus.req[m_code] || bus.done || (MAXH != 0 && m_held == int'(MAXH))) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_code + 1) % int'(N);
      m_to   <= bus.req[m_code] && !bus.done;
    end else begin
      m_held <= m_held + 1;
      m_to   <= 1'b0;
    end
  end

  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst      = r;
    bus.req  = q;
    bus.done = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] g, input logic [2:0] c,
                       input logic v, input logic t);
    total++;
    if (bus.gnt !== g || bus.gnt_code !== c || bus.gnt_valid !== v || bus.timeout !== t) begin
      bad++;
      $display("FAIL %s: got gnt=%h code=%0d valid=%b timeout=%b, want gnt=%h code=%0d valid=%b timeout=%b",
               name, bus.gnt, bus.gnt_code, bus.gnt_valid, bus.timeout, g, c, v, t);
    end
  endtask

  initial begin
    int         waits[N];
    int         maxw;
    bit         prev_valid;
    int         r;
    logic [7:0] req_v;
    int         e;

    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    @(negedge clk);

    // {rst, req, done} -> {gnt, code, valid, timeout} after the next edge
    vecs[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].code, vecs[i].valid, vecs[i].to);
    end

    // Rotation with all requesting; each owner drops after one cycle.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    for (int k = 0; k < 9; k++) begin
      e = k % int'(N);
      step(1'b0, 8'hFF, 1'b0);
      check($sformatf("rot_grant%0d", k), 8'h01 << e, 3'(e), 1'b1, 1'b0);
      step(1'b0, 8'hFF & ~(8'h01 << e), 1'b0);
      check($sformatf("rot_bubble%0d", k), 8'h00, 3'(e), 1'b0, 1'b0);
    end

    // Hold limit with only requester 3: four grant cycles, pulse, wrap back to 3.
    step(1'b1, 8'h08, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h08, 1'b0);
      check($sformatf("hold3_%0d", k), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step(1'b0, 8'h08, 1'b0);
    check("timeout3", 8'h00, 3'd3, 1'b0, 1'b1);
    step(1'b0, 8'h08, 1'b0);
    check("regrant3", 8'h08, 3'd3, 1'b1, 1'b0);

    // Same, with requester 4 waiting: it follows the timeout.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h18, 1'b0);
      check($sformatf("hold3b_%0d", k), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step(1'b0, 8'h18, 1'b0);
    check("timeout3b", 8'h00, 3'd3, 1'b0, 1'b1);
    step(1'b0, 8'h18, 1'b0);
    check("grant4", 8'h10, 3'd4, 1'b1, 1'b0);

    // done on the expiry cycle: release without timeout.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h18, 1'b0);
      check($sformatf("hold4_%0d", k), 8'h10, 3'd4, 1'b1, 1'b0);
    end
    step(1'b0, 8'h18, 1'b1);
    check("done_at_expiry", 8'h00, 3'd4, 1'b0, 1'b0);

    // Reset mid-grant clears outputs and the pointer (5 before reset, 4 after).
    step(1'b0, 8'h30, 1'b0);
    check("grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    step(1'b1, 8'h30, 1'b0);
    check("rst_midgrant", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h30, 1'b0);
    check("ptr_after_rst", 8'h10, 3'd4, 1'b1, 1'b0);

    // Random traffic against the model, plus structural and starvation checks.
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    foreach (waits[i]) waits[i] = 0;
    prev_valid = 1'b0;
    req_v      = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check($sformatf("rand%0d", cyc), m_busy ? (8'h01 << m_code) : 8'h00, 3'(m_code),
            m_busy, m_to);

      total++;
      if (!$onehot0(bus.gnt) || (bus.gnt_valid && bus.gnt != (8'h01 << bus.gnt_code)) ||
          (!bus.gnt_valid && bus.gnt != 8'h00)) begin
        bad++;
        $display("FAIL shape%0d: got gnt=%h code=%0d valid=%b, want one-hot gnt matching code",
                 cyc, bus.gnt, bus.gnt_code, bus.gnt_valid);
      end

      if (rst) begin
        foreach (waits[i]) waits[i] = 0;
      end else if (bus.gnt_valid && !prev_valid) begin
        maxw = 0;
        foreach (waits[i]) begin
          if (bus.gnt[i]) waits[i] = 0;
          else if (bus.req[i]) waits[i]++;
          else waits[i] = 0;
          if (waits[i] > maxw) maxw = waits[i];
        end
        total++;
        if (maxw > int'(N) - 1) begin
          bad++;
          $display("FAIL starve%0d: got wait=%0d grants, want at most %0d", cyc, maxw, N - 1);
        end
      end else begin
        foreach (waits[i]) if (!bus.req[i]) waits[i] = 0;
      end
      prev_valid = bus.gnt_valid;

      r = $urandom_range(0, 9);
      if (r < 2) req_v = 8'($urandom);
      else if (r == 2) req_v = 8'($urandom) & 8'($urandom);
      else if (r == 3 && $urandom_range(0, 3) == 0) req_v = 8'h00;
      if (bus.gnt_valid && $urandom_range(0, 5) == 0) req_v[bus.gnt_code] = 1'b0;
      step($urandom_range(0, 599) == 0, req_v, $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
